// File: rtl/vga_capture.sv
`default_nettype none
// ============================================================================
// Module   : vga_capture
// Purpose  : Receive side of the 640x480@60 VGA timing. Samples hsync/vsync/
//            RGB on pclk, recovers pixel coordinates from the sync edges,
//            checks the line/frame timing and, once locked to a full clean
//            frame, emits a pixel write stream for a frame buffer.
// Options  : CAPTURE_SUM_EN adds a frame_sum output, which is the mod-2^24
//            sum of all wr_data in the last completed frame.
// Revision : 1.0 - initial release
// ============================================================================
module vga_capture #(
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 145,
  parameter int H_ACT_END   = 784,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 36,
  parameter int V_ACT_END   = 515,
  parameter int V_TOTAL     = 525
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        wr_en,
  output logic [9:0]  wr_x,
  output logic [9:0]  wr_y,
  output logic [23:0] wr_data,
  output logic        frame_done,
  output logic        locked,
  output logic [7:0]  err_cnt
`ifdef CAPTURE_SUM_EN
  ,
  output logic [23:0] frame_sum
`endif
);

  // 10-bit forms of the timing parameters, matching the position counters
  localparam logic [9:0] C_H_SYNC_P1   = 10'(H_SYNC + 1);
  localparam logic [9:0] C_H_ACT_START = 10'(H_ACT_START);
  localparam logic [9:0] C_H_ACT_END   = 10'(H_ACT_END);
  localparam logic [9:0] C_H_TOTAL     = 10'(H_TOTAL);
  localparam logic [9:0] C_H_TOTAL_P1  = 10'(H_TOTAL + 1);
  localparam logic [9:0] C_V_SYNC_P1   = 10'(V_SYNC + 1);
  localparam logic [9:0] C_V_ACT_START = 10'(V_ACT_START);
  localparam logic [9:0] C_V_ACT_END   = 10'(V_ACT_END);
  localparam logic [9:0] C_V_TOTAL     = 10'(V_TOTAL);
  localparam logic [9:0] C_POS_MAX     = 10'h3FF;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_err_inc;

  logic        r_hs1;
  logic        r_vs1;
  logic        r_hs1_d;
  logic        r_vs1_d;
  logic [23:0] r_rgb1;

  logic        w_hs_fall;
  logic        w_hs_rise;
  logic        w_vs_fall;
  logic        w_vs_rise;

  logic [9:0]  r_h_pos;
  logic [9:0]  r_v_pos;
  logic [9:0]  w_h_pos;
  logic [9:0]  w_v_pos;
  logic        r_v_loaded;

  logic        w_v1;
  logic        w_v2;
  logic        w_v3;
  logic        w_v4;
  logic        w_v5;
  logic        w_viol;

  logic        w_h_act;
  logic        w_v_act;
  logic        w_wr;
  logic        w_last;
  logic [9:0]  w_x;
  logic [9:0]  w_y;

  // Stage 1: register the raw inputs and keep the previous sync samples for edge detection
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_hs1   <= 1'b1;
      r_vs1   <= 1'b1;
      r_hs1_d <= 1'b1;
      r_vs1_d <= 1'b1;
      r_rgb1  <= 24'd0;
    end else begin
      r_hs1   <= hsync;
      r_vs1   <= vsync;
      r_hs1_d <= r_hs1;
      r_vs1_d <= r_vs1;
      r_rgb1  <= {vga_r, vga_g, vga_b};
    end
  end

  assign w_hs_fall =  r_hs1_d & ~r_hs1;
  assign w_hs_rise = ~r_hs1_d &  r_hs1;
  assign w_vs_fall =  r_vs1_d & ~r_vs1;
  assign w_vs_rise = ~r_vs1_d &  r_vs1;

  // Position of the current stage-1 sample, derived from the previous position and sync edges
  always_comb begin
    w_h_pos = (r_h_pos == C_POS_MAX) ? C_POS_MAX : r_h_pos + 10'd1;
    if (w_hs_fall) begin
      w_h_pos = 10'd1;
    end
    w_v_pos = r_v_pos;
    if (w_vs_fall) begin
      w_v_pos = 10'd1;
    end else if (w_hs_fall) begin
      w_v_pos = (r_v_pos == C_POS_MAX) ? C_POS_MAX : r_v_pos + 10'd1;
    end
  end

  // Position registers; v_loaded marks that a vsync fall has anchored the line count
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_h_pos    <= 10'd0;
      r_v_pos    <= 10'd0;
      r_v_loaded <= 1'b0;
    end else begin
      r_h_pos <= w_h_pos;
      r_v_pos <= w_v_pos;
      if (w_vs_fall) begin
        r_v_loaded <= 1'b1;
      end
    end
  end

  // Timing checks. Line-length and frame-length checks compare the count that
  // was reached before the reload; the others compare the new position.
  assign w_v1   = r_v_loaded & w_hs_fall & (r_h_pos != C_H_TOTAL);
  assign w_v2   = r_v_loaded & (w_h_pos == C_H_TOTAL_P1);
  assign w_v3   = r_v_loaded & w_hs_rise & (w_h_pos != C_H_SYNC_P1);
  assign w_v4   = r_v_loaded & w_vs_fall & (r_v_pos != C_V_TOTAL);
  assign w_v5   = w_vs_rise & ~((w_v_pos == C_V_SYNC_P1) & (w_h_pos == 10'd1));
  assign w_viol = w_v1 | w_v2 | w_v3 | w_v4 | w_v5;

  // Lock state register
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_state <= ST_SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Lock FSM next state; a violation while locked also bumps the error counter
  always_comb begin
    w_state_nxt = r_state;
    w_err_inc   = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_vs_fall) begin
          w_state_nxt = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (w_viol) begin
          w_state_nxt = ST_SEARCH;
        end else if (w_vs_fall) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_viol) begin
          w_state_nxt = ST_SEARCH;
          w_err_inc   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
      end
    endcase
  end

  assign locked = (r_state == ST_LOCKED);

  // Active-window decode; a violating sample is never written
  assign w_h_act = (w_h_pos >= C_H_ACT_START) && (w_h_pos <= C_H_ACT_END);
  assign w_v_act = (w_v_pos >= C_V_ACT_START) && (w_v_pos <= C_V_ACT_END);
  assign w_wr    = locked & ~w_viol & w_h_act & w_v_act;
  assign w_x     = w_h_pos - C_H_ACT_START;
  assign w_y     = w_v_pos - C_V_ACT_START;
  // Last active pixel of the frame: (639,479) at the default timing
  assign w_last  = w_wr & (w_h_pos == C_H_ACT_END) & (w_v_pos == C_V_ACT_END);

  // Stage 2: write strobe and payload; payload holds between writes
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      wr_x       <= 10'd0;
      wr_y       <= 10'd0;
      wr_data    <= 24'd0;
    end else begin
      wr_en      <= w_wr;
      frame_done <= w_last;
      if (w_wr) begin
        wr_x    <= w_x;
        wr_y    <= w_y;
        wr_data <= r_rgb1;
      end
    end
  end

  // Saturating count of violations seen while locked
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      err_cnt <= 8'd0;
    end else if (w_err_inc && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef CAPTURE_SUM_EN
  logic [23:0] r_acc;
  logic [23:0] w_acc_nxt;

  // Pixel (0,0) restarts the running sum so a partial earlier frame never leaks in
  assign w_acc_nxt = ((w_x == 10'd0) && (w_y == 10'd0)) ? r_rgb1 : r_acc + r_rgb1;

  // Frame checksum: accumulate each write, publish on the last pixel
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_acc     <= 24'd0;
      frame_sum <= 24'd0;
    end else begin
      if (w_wr) begin
        r_acc <= w_acc_nxt;
      end
      if (w_last) begin
        frame_sum <= w_acc_nxt;
      end
    end
  end
`endif

endmodule
`default_nettype wire
